// File: rtl/ctrl_sequencer_if.sv
// Control bundle between the hardwired sequencer (master) and datapath_new (slave).
// The sequencer is the master: it reads run/mem_rdy/ir and drives every strobe and status line.
interface ctrl_sequencer_if #(
  parameter int OPW  = 5,
  parameter int NREG = 16
);
  logic            run;
  logic            mem_rdy;
  logic [31:0]     ir;
  logic            pcout;
  logic            mdrout;
  logic            zlowout;
  logic            marin;
  logic            pc_in;
  logic            MDRin;
  logic            ir_in;
  logic            y_in;
  logic            zhi_in;
  logic            zlo_in;
  logic            IncPC;
  logic            Read;
  logic [NREG-1:0] rout_sel;
  logic [NREG-1:0] rin_sel;
  logic [OPW-1:0]  alu_op;
  logic            busy;
  logic            halted;
  logic            fault;
  logic            illegal;
  logic [31:0]     instr_cnt;

  modport master (
    input  run, mem_rdy, ir,
    output pcout, mdrout, zlowout, marin, pc_in, MDRin, ir_in, y_in, zhi_in, zlo_in,
           IncPC, Read, rout_sel, rin_sel, alu_op, busy, halted, fault, illegal, instr_cnt
  );

  modport slave (
    output run, mem_rdy, ir,
    input  pcout, mdrout, zlowout, marin, pc_in, MDRin, ir_in, y_in, zhi_in, zlo_in,
           IncPC, Read, rout_sel, rin_sel, alu_op, busy, halted, fault, illegal, instr_cnt
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/execute sequencer for datapath_new: T0-T2 fetch, T3-T5 three-register ALU op,
// with a bounded memory-ready wait, NOP/HALT and illegal-opcode handling.
module ctrl_sequencer #(
  parameter int OPW         = 5,
  parameter int NREG        = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input logic              clk,
  input logic              clr,
  ctrl_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, HALT} state_t;

  localparam logic [7:0] WAIT_LAST    = 8'(MEM_TIMEOUT - 1);
  localparam logic [4:0] OP_LAST_ALU  = 5'b01000;
  localparam logic [4:0] OP_NOP       = 5'b11010;
  localparam logic [4:0] OP_HALT      = 5'b11011;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        fault_q;
  logic [31:0] cnt_q;

  logic [4:0]  op;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [3:0]  rc;
  logic        is_alu;
  logic        is_nop;
  logic        is_halt;
  logic        ir_unused;

  assign op        = bus.ir[31:27];
  assign ra        = bus.ir[26:23];
  assign rb        = bus.ir[22:19];
  assign rc        = bus.ir[18:15];
  assign is_alu    = (op <= OP_LAST_ALU);
  assign is_nop    = (op == OP_NOP);
  assign is_halt   = (op == OP_HALT);
  assign ir_unused = ^bus.ir[14:0];

  // Wait counter only advances in T1; hitting the last allowed cycle without mem_rdy is a fault.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= IDLE;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.run) state <= T0;
        T0:   state <= T1;
        T1: begin
          if (bus.mem_rdy) begin
            state    <= T2;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= HALT;
            fault_q  <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        T2:   state <= T3;
        T3: begin
          if (is_alu) begin
            state <= T4;
          end else if (is_halt) begin
            cnt_q <= cnt_q + 32'd1;
            state <= HALT;
          end else begin
            cnt_q <= cnt_q + 32'd1;
            state <= bus.run ? T0 : IDLE;
          end
        end
        T4:   state <= T5;
        T5: begin
          cnt_q <= cnt_q + 32'd1;
          state <= bus.run ? T0 : IDLE;
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // IR is only trusted from T3 onward, so register-select decodes are confined to T3-T5.
  always_comb begin
    bus.pcout    = 1'b0;
    bus.mdrout   = 1'b0;
    bus.zlowout  = 1'b0;
    bus.marin    = 1'b0;
    bus.pc_in    = 1'b0;
    bus.MDRin    = 1'b0;
    bus.ir_in    = 1'b0;
    bus.y_in     = 1'b0;
    bus.zhi_in   = 1'b0;
    bus.zlo_in   = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.rout_sel = '0;
    bus.rin_sel  = '0;
    bus.alu_op   = '0;
    bus.illegal  = 1'b0;
    case (state)
      T0: begin
        bus.pcout  = 1'b1;
        bus.marin  = 1'b1;
        bus.IncPC  = 1'b1;
        bus.zhi_in = 1'b1;
        bus.zlo_in = 1'b1;
      end
      T1: begin
        bus.zlowout = 1'b1;
        bus.pc_in   = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      T2: begin
        bus.mdrout = 1'b1;
        bus.ir_in  = 1'b1;
      end
      T3: begin
        if (is_alu) begin
          bus.rout_sel = NREG'(1) << rb;
          bus.y_in     = 1'b1;
        end else if (!is_nop && !is_halt) begin
          bus.illegal = 1'b1;
        end
      end
      T4: begin
        bus.rout_sel = NREG'(1) << rc;
        bus.alu_op   = OPW'(op);
        bus.zhi_in   = 1'b1;
        bus.zlo_in   = 1'b1;
      end
      T5: begin
        bus.zlowout = 1'b1;
        bus.rin_sel = NREG'(1) << ra;
      end
      default: ;
    endcase
  end

  assign bus.busy      = (state != IDLE) && (state != HALT);
  assign bus.halted    = (state == HALT);
  assign bus.fault     = fault_q;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: a per-cycle expected control trace is derived from
// the instruction word and the number of memory wait cycles, compared against the DUT each cycle.
module tb_ctrl_sequencer;

  localparam int OPW         = 5;
  localparam int NREG        = 16;
  localparam int MEM_TIMEOUT = 15;

  typedef struct packed {
    logic        pcout, mdrout, zlowout, marin, pc_in, MDRin, ir_in;
    logic        y_in, zhi_in, zlo_in, IncPC, Read, busy, halted, illegal;
    logic [15:0] rout_sel;
    logic [15:0] rin_sel;
    logic [4:0]  alu_op;
  } ctl_t;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] fetch_word = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          model_cnt = 0;
  int          illegal_pulses = 0;

  always #5 clk = ~clk;

  ctrl_sequencer_if #(.OPW(OPW), .NREG(NREG)) bus ();

  ctrl_sequencer #(.OPW(OPW), .NREG(NREG), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Stand-in for the datapath IR register: loads the fetched word when ir_in is strobed.
  always @(posedge clk) begin
    if (!clr) bus.ir <= '0;
    else if (bus.ir_in) bus.ir <= fetch_word;
  end

  always @(negedge clk) if (bus.illegal === 1'b1) illegal_pulses++;

  function automatic bit op_alu(input logic [4:0] op);
    return op <= 5'd8;
  endfunction

  function automatic ctl_t sample_ctl();
    ctl_t a;
    a = '{pcout: bus.pcout, mdrout: bus.mdrout, zlowout: bus.zlowout, marin: bus.marin,
          pc_in: bus.pc_in, MDRin: bus.MDRin, ir_in: bus.ir_in, y_in: bus.y_in,
          zhi_in: bus.zhi_in, zlo_in: bus.zlo_in, IncPC: bus.IncPC, Read: bus.Read,
          busy: bus.busy, halted: bus.halted, illegal: bus.illegal,
          rout_sel: bus.rout_sel, rin_sel: bus.rin_sel, alu_op: bus.alu_op};
    return a;
  endfunction

  // Cycle k of an instruction counted from T0; T1 lasts waits+1 cycles.
  function automatic ctl_t exp_ctl(input int k, input int waits, input logic [31:0] w);
    ctl_t e;
    logic [4:0] op;
    e  = '0;
    op = w[31:27];
    e.busy = 1'b1;
    if (k == 0) begin
      e.pcout = 1; e.marin = 1; e.IncPC = 1; e.zhi_in = 1; e.zlo_in = 1;
    end else if (k <= waits + 1) begin
      e.zlowout = 1; e.pc_in = 1; e.Read = 1; e.MDRin = 1;
    end else if (k == waits + 2) begin
      e.mdrout = 1; e.ir_in = 1;
    end else if (k == waits + 3) begin
      if (op_alu(op)) begin
        e.rout_sel = 16'd1 << w[22:19];
        e.y_in     = 1;
      end else if (op != 5'd26 && op != 5'd27) begin
        e.illegal = 1;
      end
    end else if (k == waits + 4) begin
      e.rout_sel = 16'd1 << w[18:15];
      e.alu_op   = op;
      e.zhi_in   = 1; e.zlo_in = 1;
    end else begin
      e.zlowout = 1;
      e.rin_sel = 16'd1 << w[26:23];
    end
    return e;
  endfunction

  task automatic start_from_idle();
    bus.run     = 1'b1;
    bus.mem_rdy = 1'b0;
    @(negedge clk);
  endtask

  // Enters at the T0 sample; run is randomised mid-instruction and set to next_run at the end.
  task automatic exec_instr(input logic [31:0] w, input int waits, input logic next_run,
                            input int max_cycles);
    int   len;
    ctl_t act, exp;
    len = op_alu(w[31:27]) ? waits + 6 : waits + 4;
    fetch_word = w;
    for (int k = 0; k < len && k < max_cycles; k++) begin
      act = sample_ctl();
      exp = exp_ctl(k, waits, w);
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("[TB] FAIL trace k=%0d word=%h: got %h, expected %h", k, w, act, exp);
      end
      if (k >= 1 && k <= waits) bus.mem_rdy = 1'b0;
      else if (k == waits + 1) bus.mem_rdy = 1'b1;
      else bus.mem_rdy = 1'($urandom_range(0, 1));
      bus.run = (k == len - 1) ? next_run : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    if (max_cycles >= len) begin
      model_cnt++;
      n_checks++;
      if (bus.instr_cnt !== 32'(model_cnt)) begin
        n_fail++;
        $display("[TB] FAIL instr_cnt word=%h: got %0d, expected %0d", w, bus.instr_cnt, model_cnt);
      end
      n_checks++;
      if (bus.fault !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL fault_clear word=%h: got %b, expected 0", w, bus.fault);
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; bus.run = 1'b0; bus.mem_rdy = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (sample_ctl() !== ctl_t'('0) || bus.fault !== 1'b0 || bus.instr_cnt !== 32'd0) begin
        n_fail++;
        $display("[TB] FAIL reset_idle: got ctl=%h fault=%b cnt=%0d, expected all 0",
                 sample_ctl(), bus.fault, bus.instr_cnt);
      end
      @(negedge clk);
    end
    model_cnt = 0;
  endtask

  task automatic test_alu_directed();
    start_from_idle();
    exec_instr(32'h2891_8000, 0, 1'b0, 100);
    n_checks++;
    if (sample_ctl() !== ctl_t'('0)) begin
      n_fail++;
      $display("[TB] FAIL alu_directed_idle: got %h, expected 0", sample_ctl());
    end
  endtask

  task automatic test_mem_wait();
    logic [31:0] w;
    w = {5'($urandom_range(0, 8)), 27'($urandom)};
    start_from_idle();
    exec_instr(w, 3, 1'b0, 100);
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [4:0]  op;
    logic        nr;
    int          sel;
    start_from_idle();
    for (int i = 0; i < 30; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6) op = 5'($urandom_range(0, 8));
      else if (sel < 8) op = 5'd26;
      else begin
        op = 5'($urandom_range(9, 31));
        if (op == 5'd27) op = 5'd31;
      end
      w  = {op, 27'($urandom)};
      nr = (i != 29) && ($urandom_range(0, 3) != 0);
      exec_instr(w, int'($urandom_range(0, 4)), nr, 100);
      if (!nr) begin
        n_checks++;
        if (sample_ctl() !== ctl_t'('0)) begin
          n_fail++;
          $display("[TB] FAIL random_idle i=%0d: got %h, expected 0", i, sample_ctl());
        end
        if (i != 29) start_from_idle();
      end
    end
  endtask

  task automatic test_nop_illegal();
    int p0;
    p0 = illegal_pulses;
    start_from_idle();
    exec_instr({5'b11010, 27'($urandom)}, 0, 1'b1, 100);
    exec_instr({5'b11111, 27'($urandom)}, 1, 1'b0, 100);
    n_checks++;
    if (illegal_pulses - p0 !== 1) begin
      n_fail++;
      $display("[TB] FAIL illegal_pulses: got %0d, expected 1", illegal_pulses - p0);
    end
  endtask

  task automatic test_reset_mid_instr();
    start_from_idle();
    exec_instr({5'd3, 27'($urandom)}, 0, 1'b1, 4);
    clr = 1'b0; bus.run = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    model_cnt = 0;
    n_checks++;
    if (sample_ctl() !== ctl_t'('0) || bus.fault !== 1'b0 || bus.instr_cnt !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_t4: got ctl=%h fault=%b cnt=%0d, expected all 0",
               sample_ctl(), bus.fault, bus.instr_cnt);
    end
  endtask

  task automatic test_timeout();
    ctl_t hx;
    hx = '0; hx.halted = 1'b1;
    start_from_idle();
    fetch_word = {5'd1, 27'($urandom)};
    for (int k = 0; k <= MEM_TIMEOUT; k++) begin
      n_checks++;
      if (sample_ctl() !== exp_ctl(k, 1000, fetch_word)) begin
        n_fail++;
        $display("[TB] FAIL timeout_wait k=%0d: got %h, expected %h", k, sample_ctl(),
                 exp_ctl(k, 1000, fetch_word));
      end
      bus.mem_rdy = 1'b0;
      bus.run = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (sample_ctl() !== hx || bus.fault !== 1'b1 || bus.instr_cnt !== 32'(model_cnt)) begin
        n_fail++;
        $display("[TB] FAIL timeout_halt i=%0d: got ctl=%h fault=%b cnt=%0d, expected %h 1 %0d",
                 i, sample_ctl(), bus.fault, bus.instr_cnt, hx, model_cnt);
      end
      bus.run = 1'($urandom_range(0, 1));
      bus.mem_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    clr = 1'b0; bus.run = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    model_cnt = 0;
    n_checks++;
    if (sample_ctl() !== ctl_t'('0) || bus.fault !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL timeout_recover: got ctl=%h fault=%b, expected 0 0", sample_ctl(), bus.fault);
    end
  endtask

  task automatic test_halt();
    ctl_t hx;
    hx = '0; hx.halted = 1'b1;
    start_from_idle();
    exec_instr({5'b11011, 27'($urandom)}, int'($urandom_range(0, 3)), 1'b1, 100);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (sample_ctl() !== hx) begin
        n_fail++;
        $display("[TB] FAIL halt_state i=%0d: got %h, expected %h", i, sample_ctl(), hx);
      end
      bus.run = 1'($urandom_range(0, 1));
      bus.mem_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    clr = 1'b0; bus.run = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    model_cnt = 0;
    n_checks++;
    if (sample_ctl() !== ctl_t'('0) || bus.fault !== 1'b0 || bus.instr_cnt !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL halt_recover: got ctl=%h fault=%b cnt=%0d, expected all 0",
               sample_ctl(), bus.fault, bus.instr_cnt);
    end
  endtask

  initial begin
    bus.run = 1'b0;
    bus.mem_rdy = 1'b0;
    test_reset();
    test_alu_directed();
    test_mem_wait();
    test_random();
    test_nop_illegal();
    test_reset_mid_instr();
    test_timeout();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
